// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// Combinational single-bit comparator cell, reused every bit-cycle by the sequencer.
module bit_cmp_cell (
    input  logic a_i,
    input  logic b_i,
    output logic eq_o,
    output logic neq_o,
    output logic l_o,
    output logic g_o
);

    assign l_o   = ~a_i & b_i;
    assign g_o   = a_i & ~b_i;
    assign neq_o = a_i ^ b_i;
    assign eq_o  = ~(a_i ^ b_i);

endmodule

// File: rtl/serial_magnitude_cmp_ctrl.sv
// Bit-serial MSB-first unsigned magnitude comparator with valid/ready on both the
// operand and the result side; one shared bit_cmp_cell does all the comparing.
module serial_magnitude_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  bit EARLY_EXIT = 1'b1,
    localparam int CW         = cnt_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             eq_o,
    output logic             neq_o,
    output logic             l_o,
    output logic             g_o,
    output logic             busy_o,
    output logic [CW-1:0]    cycles_o
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] sa_q, sb_q;
    logic [CW-1:0]    idx_q, cycles_q;
    logic             ls_q, gs_q;
    logic             eq_q, neq_q, l_q, g_q;

    logic cell_eq, cell_neq, cell_l, cell_g;
    logic decided, finish;
    logic fl_eq, fl_neq, fl_l, fl_g;

    bit_cmp_cell u_cell (
        .a_i   (sa_q[WIDTH-1]),
        .b_i   (sb_q[WIDTH-1]),
        .eq_o  (cell_eq),
        .neq_o (cell_neq),
        .l_o   (cell_l),
        .g_o   (cell_g)
    );

    // Once a higher bit has differed, the sticky flags own the decision.
    assign decided = ls_q | gs_q;
    assign finish  = (EARLY_EXIT && cell_neq) || (idx_q == '0);

    always_comb begin
        fl_l   = decided ? ls_q : cell_l;
        fl_g   = decided ? gs_q : cell_g;
        fl_neq = decided | cell_neq;
        fl_eq  = ~decided & cell_eq;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid_i) state_d = SHIFT;
            SHIFT:   if (finish)        state_d = DONE;
            DONE:    if (res_ready_i)   state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready_o = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        res_valid_o   = (state_q == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sa_q     <= '0;
            sb_q     <= '0;
            idx_q    <= '0;
            cycles_q <= '0;
            ls_q     <= 1'b0;
            gs_q     <= 1'b0;
            eq_q     <= 1'b0;
            neq_q    <= 1'b0;
            l_q      <= 1'b0;
            g_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid_i) begin
                        sa_q     <= a_i;
                        sb_q     <= b_i;
                        idx_q    <= CW'(WIDTH - 1);
                        cycles_q <= '0;
                        ls_q     <= 1'b0;
                        gs_q     <= 1'b0;
                    end
                end
                SHIFT: begin
                    cycles_q <= cycles_q + CW'(1);
                    if (!decided) begin
                        ls_q <= cell_l;
                        gs_q <= cell_g;
                    end
                    sa_q  <= sa_q << 1;
                    sb_q  <= sb_q << 1;
                    idx_q <= idx_q - CW'(1);
                    if (finish) begin
                        eq_q  <= fl_eq;
                        neq_q <= fl_neq;
                        l_q   <= fl_l;
                        g_q   <= fl_g;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eq_o     = eq_q;
    assign neq_o    = neq_q;
    assign l_o      = l_q;
    assign g_o      = g_q;
    assign cycles_o = cycles_q;

endmodule

// File: tb/tb_serial_magnitude_cmp_ctrl.sv
// Scoreboard bench driving an early-exit and a constant-latency comparator in parallel.
module tb_serial_magnitude_cmp_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic eq;
        logic neq;
        logic l;
        logic g;
        int   cycles;
        int   startCyc;
    } expT;

    logic clk = 1'b0;
    logic rst;
    logic startValid;
    logic resReady;
    logic [W-1:0] aIn, bIn;

    logic [1:0]         startReady, resValid, eqOut, neqOut, lOut, gOut, busyOut;
    logic [1:0][CW-1:0] cycOut;

    expT scb0[$];
    expT scb1[$];

    int   checks = 0;
    int   fails = 0;
    int   cycCount = 0;
    logic [1:0] prevRv = 2'b00;
    bit   randomMode = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    // Instance index equals its EARLY_EXIT setting.
    serial_magnitude_cmp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dutEarly (
        .clk_i(clk), .rst_i(rst),
        .start_valid_i(startValid), .start_ready_o(startReady[1]),
        .a_i(aIn), .b_i(bIn),
        .res_valid_o(resValid[1]), .res_ready_i(resReady),
        .eq_o(eqOut[1]), .neq_o(neqOut[1]), .l_o(lOut[1]), .g_o(gOut[1]),
        .busy_o(busyOut[1]), .cycles_o(cycOut[1])
    );

    serial_magnitude_cmp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dutConst (
        .clk_i(clk), .rst_i(rst),
        .start_valid_i(startValid), .start_ready_o(startReady[0]),
        .a_i(aIn), .b_i(bIn),
        .res_valid_o(resValid[0]), .res_ready_i(resReady),
        .eq_o(eqOut[0]), .neq_o(neqOut[0]), .l_o(lOut[0]), .g_o(gOut[0]),
        .busy_o(busyOut[0]), .cycles_o(cycOut[0])
    );

    function automatic expT model(input logic [W-1:0] a, input logic [W-1:0] b, input bit early);
        expT e;
        logic [W-1:0] d;
        int p;
        e.eq  = (a == b);
        e.neq = (a != b);
        e.l   = (a < b);
        e.g   = (a > b);
        d = a ^ b;
        p = -1;
        for (int i = 0; i < W; i++) if (d[i]) p = i;
        e.cycles   = (early && p >= 0) ? (W - p) : W;
        e.startCyc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s_dut%0d_start_ready", tag, i), int'(startReady[i]), 1);
            checkOutput($sformatf("%s_dut%0d_res_valid", tag, i), int'(resValid[i]), 0);
            checkOutput($sformatf("%s_dut%0d_flags", tag, i),
                        int'({eqOut[i], neqOut[i], lOut[i], gOut[i]}), 0);
            checkOutput($sformatf("%s_dut%0d_busy", tag, i), int'(busyOut[i]), 0);
            checkOutput($sformatf("%s_dut%0d_cycles", tag, i), int'(cycOut[i]), 0);
        end
    endtask

    task automatic waitBothReady();
        int n = 0;
        while (startReady != 2'b11 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("wait_start_ready", int'(startReady), 3);
    endtask

    task automatic pushExp(input logic [W-1:0] a, input logic [W-1:0] b);
        expT e;
        e = model(a, b, 1'b1);
        e.startCyc = cycCount;
        scb1.push_back(e);
        e = model(a, b, 1'b0);
        e.startCyc = cycCount;
        scb0.push_back(e);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        waitBothReady();
        aIn = a;
        bIn = b;
        startValid = 1'b1;
        @(posedge clk); #1;
        pushExp(a, b);
        startValid = 1'b0;
        aIn = ~a;
        bIn = ~b;
    endtask

    task automatic monitorPort(input int i);
        expT e;
        bit have;
        have = (i == 1) ? (scb1.size() > 0) : (scb0.size() > 0);
        if (have) e = (i == 1) ? scb1[0] : scb0[0];
        if (resValid[i] && !prevRv[i] && have)
            checkOutput($sformatf("dut%0d_latency", i), cycCount - e.startCyc, e.cycles);
        if (resValid[i] && resReady) begin
            checkOutput($sformatf("dut%0d_result_expected", i), int'(have), 1);
            if (have) begin
                checkOutput($sformatf("dut%0d_eq", i), int'(eqOut[i]), int'(e.eq));
                checkOutput($sformatf("dut%0d_neq", i), int'(neqOut[i]), int'(e.neq));
                checkOutput($sformatf("dut%0d_l", i), int'(lOut[i]), int'(e.l));
                checkOutput($sformatf("dut%0d_g", i), int'(gOut[i]), int'(e.g));
                checkOutput($sformatf("dut%0d_cycles", i), int'(cycOut[i]), e.cycles);
                if (i == 1) void'(scb1.pop_front());
                else        void'(scb0.pop_front());
            end
        end
        prevRv[i] = resValid[i];
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prevRv = 2'b00;
        end else begin
            monitorPort(0);
            monitorPort(1);
        end
    end

    always @(posedge clk) begin
        #1;
        if (randomMode) resReady = ($urandom_range(0, 2) != 0);
    end

    initial begin
        logic [W-1:0] ra, rb;
        int n;
        rst = 1'b1;
        startValid = 1'b0;
        resReady = 1'b1;
        aIn = '0;
        bIn = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk); #1;

        applyStimulus(8'hA5, 8'hA5);
        applyStimulus(8'h80, 8'h7F);
        applyStimulus(8'h12, 8'h13);
        applyStimulus(8'h40, 8'h3F);
        applyStimulus(8'h00, 8'hFF);

        // Stalled result with start_valid held high throughout.
        waitBothReady();
        aIn = 8'h80;
        bIn = 8'h7F;
        startValid = 1'b1;
        resReady = 1'b0;
        @(posedge clk); #1;
        pushExp(8'h80, 8'h7F);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_res_valid", int'(resValid[1]), 1);
            checkOutput("bp_g", int'(gOut[1]), 1);
            checkOutput("bp_cycles", int'(cycOut[1]), 1);
            checkOutput("bp_start_ready", int'(startReady[1]), 0);
            @(posedge clk); #1;
        end
        resReady = 1'b1;
        @(posedge clk); #1;
        startValid = 1'b0;
        @(negedge clk);
        checkOutput("bp_idle_busy", int'(busyOut[1]), 0);
        checkOutput("bp_idle_start_ready", int'(startReady[1]), 1);
        @(posedge clk); #1;

        // Reset lands in the third SHIFT cycle; the operation is discarded.
        applyStimulus(8'h01, 8'h00);
        @(posedge clk); #1;
        checkOutput("midreset_busy_before", int'(busyOut), 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        scb0.delete();
        scb1.delete();
        @(negedge clk);
        checkResetState("midreset");
        @(posedge clk); #1;

        randomMode = 1'b1;
        for (int t = 0; t < 60; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
            endcase
            applyStimulus(ra, rb);
        end
        randomMode = 1'b0;
        @(posedge clk); #1;
        resReady = 1'b1;

        n = 0;
        while ((scb0.size() + scb1.size()) > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_pending", scb0.size() + scb1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
